vrf_addr_sequencer: RTL and testbench
=====================================

Name: vrf_addr_sequencer

Overview:
- Per-operation VRF address walker for the vector lanes.
- Consumes the eight packed per-register starting addresses produced for vs1, vs2 and vd, one slot per register of an LMUL group.
- Steps through the words of the group one per cycle, driving VRF read ports 0/1 and, after a fixed datapath latency, the VRF write port.
- Sits between the control unit's renaming stage and the lane VRF banks; a start/ready handshake fronts it and done_o pulses on completion.

Parameters:
- VLEN, 4096, vector register length in bits.
- VLANE_NUM, 8, number of lanes; MEM_DEPTH=VLEN/VLANE_NUM, AW=$clog2(MEM_DEPTH) (9 at defaults).
- PIPE_LATENCY, 4, cycles from read issue to the matching write (must be >=1).
- Derived REG_WORDS=VLEN/32/VLANE_NUM (16 at defaults): words per register per lane.

Ports:
- clk  input  1  clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- start_i  input  1  request a new operation; accepted when start_i && ready_o.
- ready_o  output  1  high only in IDLE.
- vrf_starting_raddr0_i  input  8*AW  packed start addresses, register slot k at [k*AW +: AW], read port 0.
- vrf_starting_raddr1_i  input  8*AW  same packing, read port 1.
- vrf_starting_waddr_i  input  8*AW  same packing, write port.
- lmul_i  input  2  group size 1<<lmul_i registers (0..3 -> 1,2,4,8).
- word_cnt_i  input  $clog2(8*REG_WORDS)+1  words per lane to process (0..128 at defaults).
- stall_i  input  1  freezes all sequencing state while high.
- vrf_ren_o  output  1  read strobe.
- vrf_raddr0_o  output  AW  read port 0 address.
- vrf_raddr1_o  output  AW  read port 1 address.
- vrf_wen_o  output  1  write strobe.
- vrf_waddr_o  output  AW  write address.
- done_o  output  1  one-cycle pulse when the final write has been issued.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, ready_o=1, every other output 0, all counters 0, valid shift register cleared.
- Reset asserted mid-operation aborts the operation immediately; no further strobes are issued.
- On accept, latch all three address buses and lmul_i.
- Effective count N = min(word_cnt_i, (1<<lmul_i)*REG_WORDS).
- States: IDLE, READ, DRAIN, DONE.
- IDLE to READ on accept when N>0. IDLE to DONE on accept when N=0.
- READ, each non-stalled cycle:
  - Assert vrf_ren_o, with vrf_raddr0_o = slot0[rd_reg] + rd_word and vrf_raddr1_o = slot1[rd_reg] + rd_word. Addition is AW-bit modulo; no carry out.
  - rd_word increments; when it reaches REG_WORDS-1 it wraps to 0 and rd_reg increments.
  - After issuing read N, go to DRAIN.
- Outputs are registered: an address appears one cycle after the state/counter update that selects it. ren/wen are 0 in every cycle where no access is issued.
- Write side:
  - A PIPE_LATENCY-deep valid shift register is loaded with each issued read.
  - When a valid emerges, assert vrf_wen_o with vrf_waddr_o = slotW[wr_reg] + wr_word. wr_word/wr_reg advance with the same wrap rule as the read counters.
  - Writes therefore trail reads by exactly PIPE_LATENCY non-stalled cycles.
- DRAIN: no reads. Go to DONE in the same cycle the Nth write is issued.
- DONE: done_o=1 for exactly one cycle, then IDLE. ready_o=0 in DONE.
- stall_i high: state, counters and the shift register all hold; vrf_ren_o=vrf_wen_o=0 that cycle; done_o is deferred until stall_i is low.
- stall_i has no effect in IDLE.
- start_i is ignored outside IDLE, and inputs may change after accept.
- Slots at index >= (1<<lmul_i) are never addressed.

Test Plan:
- LMUL=1, N=3, raddr0 slot0=32, raddr1 slot0=64, waddr slot0=96:
  - Reads 32/64, 33/65, 34/66 on three consecutive cycles.
  - Writes 96, 97, 98 exactly 4 cycles after each read.
  - done_o one cycle after the write to 98; ready_o returns high the following cycle.
- LMUL=2, N=18, slot0=0, slot1=160 on raddr0:
  - Reads 0..15 on port 0.
  - Then reads 160, 161 (register wrap).
  - The write side shows the same wrap.
- N=0 with start:
  - No ren/wen.
  - done_o pulses on the cycle after accept.
- word_cnt_i=40, LMUL=1 (clamp): exactly 16 reads and 16 writes, then done_o.
- stall_i high for 2 cycles mid-READ:
  - No strobes during the stall.
  - Addresses resume at the next word without skips or repeats.
  - The write lag stays at 4 non-stalled cycles.
- Reset pulled low after 5 reads of an N=16 operation:
  - All outputs 0 immediately and ready_o=1.
  - A new start then begins from word 0.

Source files
------------

// File: rtl/vrf_addr_sequencer_if.sv
// Handshake and VRF address bus between the rename stage, the address walker and the lane VRF banks.
interface vrf_addr_sequencer_if #(
   parameter int AW = 9,
   parameter int CW = 8
);
   logic            start_i;
   logic            ready_o;
   logic [8*AW-1:0] vrf_starting_raddr0_i;
   logic [8*AW-1:0] vrf_starting_raddr1_i;
   logic [8*AW-1:0] vrf_starting_waddr_i;
   logic [1:0]      lmul_i;
   logic [CW-1:0]   word_cnt_i;
   logic            stall_i;
   logic            vrf_ren_o;
   logic [AW-1:0]   vrf_raddr0_o;
   logic [AW-1:0]   vrf_raddr1_o;
   logic            vrf_wen_o;
   logic [AW-1:0]   vrf_waddr_o;
   logic            done_o;

   modport master (
      output start_i, vrf_starting_raddr0_i, vrf_starting_raddr1_i, vrf_starting_waddr_i,
             lmul_i, word_cnt_i, stall_i,
      input  ready_o, vrf_ren_o, vrf_raddr0_o, vrf_raddr1_o, vrf_wen_o, vrf_waddr_o, done_o
   );

   modport slave (
      input  start_i, vrf_starting_raddr0_i, vrf_starting_raddr1_i, vrf_starting_waddr_i,
             lmul_i, word_cnt_i, stall_i,
      output ready_o, vrf_ren_o, vrf_raddr0_o, vrf_raddr1_o, vrf_wen_o, vrf_waddr_o, done_o
   );
endinterface

// File: rtl/vrf_addr_sequencer.sv
// Per-operation VRF address walker: issues one read per cycle across an LMUL register group and
// replays the same word order on the write port PIPE_LATENCY non-stalled cycles later.
module vrf_addr_sequencer #(
   parameter int VLEN         = 4096,
   parameter int VLANE_NUM    = 8,
   parameter int PIPE_LATENCY = 4
) (
   input logic                 clk,
   input logic                 rstn,
   vrf_addr_sequencer_if.slave bus
);
   localparam int MEM_DEPTH = VLEN / VLANE_NUM;
   localparam int AW        = $clog2(MEM_DEPTH);
   localparam int REG_WORDS = VLEN / 32 / VLANE_NUM;
   localparam int WW        = $clog2(REG_WORDS);
   localparam int CW        = $clog2(8 * REG_WORDS) + 1;
   localparam int PL        = PIPE_LATENCY;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]      state_r, state_nx_s;
   logic [8*AW-1:0] slot0_r, slot1_r, slotw_r;
   logic [CW-1:0]   n_r, rd_cnt_r, wr_cnt_r;
   logic [WW-1:0]   rd_word_r, wr_word_r;
   logic [2:0]      rd_reg_r, wr_reg_r;
   logic [PL-1:0]   vld_r;
   logic            ren_r, wen_r, done_r, ready_r;
   logic [AW-1:0]   raddr0_r, raddr1_r, waddr_r;
   logic            accept_s, issue_rd_s, issue_wr_s, last_rd_s, last_wr_s, active_s;
   logic [CW-1:0]   cap_s, n_s;

   assign accept_s   = bus.start_i && ready_r;
   assign cap_s      = CW'(REG_WORDS) << bus.lmul_i;
   assign n_s        = (bus.word_cnt_i < cap_s) ? bus.word_cnt_i : cap_s;
   assign active_s   = (state_r == READ) || (state_r == DRAIN);
   assign issue_rd_s = (state_r == READ) && !bus.stall_i;
   assign issue_wr_s = active_s && vld_r[PL-1] && !bus.stall_i;
   assign last_rd_s  = (rd_cnt_r == n_r - CW'(1));
   assign last_wr_s  = (wr_cnt_r == n_r - CW'(1));

   // Next-state selection for the walker FSM.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nx_s = (n_s == CW'(0)) ? DONE : READ;
            end else begin
               state_nx_s = IDLE;
            end
         end
         READ: begin
            if (issue_rd_s && last_rd_s) begin
               state_nx_s = DRAIN;
            end else begin
               state_nx_s = READ;
            end
         end
         DRAIN: begin
            if (issue_wr_s && last_wr_s) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = DRAIN;
            end
         end
         DONE: begin
            if (bus.stall_i) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = IDLE;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // Sequencing state, latched operands, valid pipe and registered port outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= IDLE;
         slot0_r   <= '0;
         slot1_r   <= '0;
         slotw_r   <= '0;
         n_r       <= '0;
         rd_cnt_r  <= '0;
         wr_cnt_r  <= '0;
         rd_word_r <= '0;
         wr_word_r <= '0;
         rd_reg_r  <= 3'd0;
         wr_reg_r  <= 3'd0;
         vld_r     <= '0;
         ren_r     <= 1'b0;
         wen_r     <= 1'b0;
         done_r    <= 1'b0;
         ready_r   <= 1'b1;
         raddr0_r  <= '0;
         raddr1_r  <= '0;
         waddr_r   <= '0;
      end else begin
         state_r <= state_nx_s;
         ready_r <= (state_r == IDLE) && !accept_s;
         ren_r   <= issue_rd_s;
         wen_r   <= issue_wr_s;
         done_r  <= (state_r == DONE) && !bus.stall_i;
         if (accept_s) begin
            slot0_r   <= bus.vrf_starting_raddr0_i;
            slot1_r   <= bus.vrf_starting_raddr1_i;
            slotw_r   <= bus.vrf_starting_waddr_i;
            n_r       <= n_s;
            rd_cnt_r  <= '0;
            wr_cnt_r  <= '0;
            rd_word_r <= '0;
            wr_word_r <= '0;
            rd_reg_r  <= 3'd0;
            wr_reg_r  <= 3'd0;
            vld_r     <= '0;
         end else begin
            if (issue_rd_s) begin
               raddr0_r  <= slot0_r[rd_reg_r*AW +: AW] + AW'(rd_word_r);
               raddr1_r  <= slot1_r[rd_reg_r*AW +: AW] + AW'(rd_word_r);
               rd_cnt_r  <= rd_cnt_r + CW'(1);
               rd_word_r <= (rd_word_r == WW'(REG_WORDS - 1)) ? WW'(0) : rd_word_r + WW'(1);
               rd_reg_r  <= (rd_word_r == WW'(REG_WORDS - 1)) ? rd_reg_r + 3'd1 : rd_reg_r;
            end
            // The valid pipe only advances on non-stalled cycles so the write lag is stall-invariant.
            if (active_s && !bus.stall_i) begin
               for (int i = PL - 1; i > 0; i--) begin
                  vld_r[i] <= vld_r[i-1];
               end
               vld_r[0] <= issue_rd_s;
            end
            if (issue_wr_s) begin
               waddr_r   <= slotw_r[wr_reg_r*AW +: AW] + AW'(wr_word_r);
               wr_cnt_r  <= wr_cnt_r + CW'(1);
               wr_word_r <= (wr_word_r == WW'(REG_WORDS - 1)) ? WW'(0) : wr_word_r + WW'(1);
               wr_reg_r  <= (wr_word_r == WW'(REG_WORDS - 1)) ? wr_reg_r + 3'd1 : wr_reg_r;
            end
         end
      end
   end

   assign bus.ready_o      = ready_r;
   assign bus.vrf_ren_o    = ren_r;
   assign bus.vrf_raddr0_o = raddr0_r;
   assign bus.vrf_raddr1_o = raddr1_r;
   assign bus.vrf_wen_o    = wen_r;
   assign bus.vrf_waddr_o  = waddr_r;
   assign bus.done_o       = done_r;
endmodule

// File: tb/tb_vrf_addr_sequencer.sv
// Scoreboard bench for vrf_addr_sequencer: stimulus queues expected reads, writes and completions;
// a negedge monitor pops and compares them as the DUT strobes.
module tb_vrf_addr_sequencer;
   localparam int AW  = 9;
   localparam int CW  = 8;
   localparam int RW  = 16;
   localparam int LAT = 4;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   vrf_addr_sequencer_if #(.AW(AW), .CW(CW)) bus ();

   vrf_addr_sequencer #(.VLEN(4096), .VLANE_NUM(8), .PIPE_LATENCY(LAT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
   } rd_t;

   rd_t           exp_rd[$];
   logic [AW-1:0] exp_wr[$];
   int            exp_done[$];
   int            rd_stamp[$];

   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   int   ns = 0;
   logic last_stall = 1'b0;
   int   rd_op = 0, wr_op = 0, done_seen = 0, acc_cyc = 0, last_wen_cyc = 0;
   logic ready_next = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic [8*AW-1:0] pk(input int s0, input int s1, input int s2, input int s3,
                                          input int s4, input int s5, input int s6, input int s7);
      int s[8];
      logic [8*AW-1:0] v;
      s = '{s0, s1, s2, s3, s4, s5, s6, s7};
      v = '0;
      for (int k = 0; k < 8; k++) v[k*AW +: AW] = AW'(s[k]);
      return v;
   endfunction

   // Cycle and non-stalled-edge counters
   always @(posedge clk) begin
      cyc        <= cyc + 1;
      ns         <= bus.stall_i ? ns : ns + 1;
      last_stall <= bus.stall_i;
   end

   // Monitor: pops expectations whenever the DUT strobes
   always @(negedge clk) begin
      if (rstn) begin
         if (last_stall) begin
            chk("ren_during_stall", bus.vrf_ren_o, 0);
            chk("wen_during_stall", bus.vrf_wen_o, 0);
         end
         if (ready_next) begin
            chk("ready_after_done", bus.ready_o, 1);
            ready_next = 1'b0;
         end
         if (bus.vrf_ren_o) begin
            rd_op++;
            if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
            else begin
               rd_t e;
               e = exp_rd.pop_front();
               chk("raddr0", bus.vrf_raddr0_o, e.a0);
               chk("raddr1", bus.vrf_raddr1_o, e.a1);
            end
            rd_stamp.push_back(ns);
         end
         if (bus.vrf_wen_o) begin
            wr_op++;
            last_wen_cyc = cyc;
            if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
            else chk("waddr", bus.vrf_waddr_o, exp_wr.pop_front());
            if (rd_stamp.size() == 0) chk("write_without_read", 1, 0);
            else chk("write_lag", ns - rd_stamp.pop_front(), LAT);
         end
         if (bus.done_o) begin
            if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               int n;
               n = exp_done.pop_front();
               chk("reads_per_op", rd_op, n);
               chk("writes_per_op", wr_op, n);
               if (n == 0) chk("done_after_accept", cyc - acc_cyc, 1);
               else chk("done_after_last_write", cyc - last_wen_cyc, 1);
            end
            chk("ready_low_at_done", bus.ready_o, 0);
            ready_next = 1'b1;
            rd_op = 0;
            wr_op = 0;
            done_seen++;
         end
      end
   end

   task automatic op(input logic [8*AW-1:0] b0, input logic [8*AW-1:0] b1, input logic [8*AW-1:0] bw,
                     input int lmul, input int wc, input int stall_after, input int abort_after);
      int n, cap, d0, k;
      logic [AW-1:0] t0, t1, tw;
      cap = RW << lmul;
      n   = (wc < cap) ? wc : cap;
      for (int i = 0; i < n; i++) begin
         t0 = b0[(i/RW)*AW +: AW] + AW'(i % RW);
         t1 = b1[(i/RW)*AW +: AW] + AW'(i % RW);
         tw = bw[(i/RW)*AW +: AW] + AW'(i % RW);
         exp_rd.push_back('{a0: t0, a1: t1});
         exp_wr.push_back(tw);
      end
      exp_done.push_back(n);
      d0 = done_seen;
      for (k = 0; k < 50 && !bus.ready_o; k++) @(negedge clk);
      chk("ready_before_start", bus.ready_o, 1);
      @(negedge clk);
      bus.vrf_starting_raddr0_i = b0;
      bus.vrf_starting_raddr1_i = b1;
      bus.vrf_starting_waddr_i  = bw;
      bus.lmul_i                = 2'(lmul);
      bus.word_cnt_i            = CW'(wc);
      bus.start_i               = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc                   = cyc;
      bus.start_i               = 1'b0;
      bus.vrf_starting_raddr0_i = ~b0;
      bus.vrf_starting_raddr1_i = ~b1;
      bus.vrf_starting_waddr_i  = ~bw;
      bus.lmul_i                = 2'd3;
      bus.word_cnt_i            = CW'(5);
      if (stall_after > 0) begin
         repeat (stall_after) @(posedge clk);
         #1 bus.stall_i = 1'b1;
         repeat (2) @(posedge clk);
         #1 bus.stall_i = 1'b0;
      end
      if (abort_after > 0) begin
         for (k = 0; k < 100 && rd_op < abort_after; k++) begin
            @(negedge clk);
            #1;
         end
         chk("reads_before_abort", rd_op, abort_after);
         rstn = 1'b0;
         #1;
         chk("abort_ren", bus.vrf_ren_o, 0);
         chk("abort_wen", bus.vrf_wen_o, 0);
         chk("abort_done", bus.done_o, 0);
         chk("abort_raddr0", bus.vrf_raddr0_o, 0);
         chk("abort_waddr", bus.vrf_waddr_o, 0);
         chk("abort_ready", bus.ready_o, 1);
         exp_rd.delete();
         exp_wr.delete();
         exp_done.delete();
         rd_stamp.delete();
         rd_op      = 0;
         wr_op      = 0;
         ready_next = 1'b0;
         @(posedge clk);
         #2 rstn = 1'b1;
      end else begin
         for (k = 0; k < 400 && done_seen == d0; k++) @(posedge clk);
         chk("done_seen", done_seen - d0, 1);
      end
   endtask

   initial begin
      bus.start_i               = 1'b0;
      bus.stall_i               = 1'b0;
      bus.vrf_starting_raddr0_i = '0;
      bus.vrf_starting_raddr1_i = '0;
      bus.vrf_starting_waddr_i  = '0;
      bus.lmul_i                = 2'd0;
      bus.word_cnt_i            = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", bus.ready_o, 1);
      chk("reset_ren", bus.vrf_ren_o, 0);
      chk("reset_wen", bus.vrf_wen_o, 0);
      chk("reset_done", bus.done_o, 0);
      @(negedge clk);
      rstn = 1'b1;

      op(pk(32, 1, 2, 3, 4, 5, 6, 7), pk(64, 11, 12, 13, 14, 15, 16, 17),
         pk(96, 21, 22, 23, 24, 25, 26, 27), 0, 3, 0, 0);
      op(pk(0, 160, 300, 310, 320, 330, 340, 350), pk(10, 200, 301, 311, 321, 331, 341, 351),
         pk(250, 400, 302, 312, 322, 332, 342, 352), 1, 18, 0, 0);
      op(pk(40, 41, 42, 43, 44, 45, 46, 47), pk(50, 51, 52, 53, 54, 55, 56, 57),
         pk(60, 61, 62, 63, 64, 65, 66, 67), 2, 0, 0, 0);
      op(pk(128, 1, 2, 3, 4, 5, 6, 7), pk(256, 11, 12, 13, 14, 15, 16, 17),
         pk(384, 21, 22, 23, 24, 25, 26, 27), 0, 40, 0, 0);
      op(pk(70, 1, 2, 3, 4, 5, 6, 7), pk(80, 11, 12, 13, 14, 15, 16, 17),
         pk(90, 21, 22, 23, 24, 25, 26, 27), 0, 10, 3, 0);
      op(pk(500, 100, 200, 300, 400, 450, 470, 490), pk(0, 16, 32, 48, 64, 80, 96, 112),
         pk(505, 120, 220, 320, 420, 460, 480, 495), 3, 70, 0, 0);
      op(pk(32, 1, 2, 3, 4, 5, 6, 7), pk(64, 11, 12, 13, 14, 15, 16, 17),
         pk(96, 21, 22, 23, 24, 25, 26, 27), 0, 16, 0, 5);
      op(pk(32, 1, 2, 3, 4, 5, 6, 7), pk(64, 11, 12, 13, 14, 15, 16, 17),
         pk(96, 21, 22, 23, 24, 25, 26, 27), 0, 4, 0, 0);

      repeat (3) @(posedge clk);
      chk("leftover_reads", exp_rd.size(), 0);
      chk("leftover_writes", exp_wr.size(), 0);
      chk("leftover_done", exp_done.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
